// File: rtl/bp_gshare_pkg.sv
// Shared encodings for the gshare predictor: 2-bit counter values, sweep FSM states
// and the BTB tag width helper.
package bp_gshare_pkg;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    localparam logic [1:0] PHT_RESET_VAL = CTR_WNT;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    // Word-aligned PCs: the two low bits never reach the index or the tag.
    function automatic int tag_width(input int pc_w, input int btb_idx_w);
        return pc_w - btb_idx_w - 2;
    endfunction

endpackage

// File: rtl/bp_gshare_if.sv
// Fetch-request, prediction and resolve-update bundle between the IF pipe and bp_gshare.
interface bp_gshare_if #(
    parameter int PC_W  = 32,
    parameter int GHR_W = 8
);
    logic             req_valid;
    logic [PC_W-1:0]  req_pc;
    logic             if_allowin;
    logic             bp_ready;

    logic             pred_valid;
    logic             pred_taken;
    logic [1:0]       pred_state;
    logic             pred_btb_hit;
    logic [PC_W-1:0]  pred_target;
    logic [GHR_W-1:0] pred_ghr;

    logic             upd_valid;
    logic [PC_W-1:0]  upd_pc;
    logic             upd_is_br;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_target;
    logic [1:0]       upd_state;
    logic [GHR_W-1:0] upd_ghr;
    logic             upd_mispredict;

    modport master (
        output req_valid, req_pc, if_allowin,
        output upd_valid, upd_pc, upd_is_br, upd_taken, upd_target,
        output upd_state, upd_ghr, upd_mispredict,
        input  bp_ready, pred_valid, pred_taken, pred_state,
        input  pred_btb_hit, pred_target, pred_ghr
    );

    modport slave (
        input  req_valid, req_pc, if_allowin,
        input  upd_valid, upd_pc, upd_is_br, upd_taken, upd_target,
        input  upd_state, upd_ghr, upd_mispredict,
        output bp_ready, pred_valid, pred_taken, pred_state,
        output pred_btb_hit, pred_target, pred_ghr
    );

endinterface

// File: rtl/bp_gshare_pht.sv
// Pattern history table: init sweep FSM, saturating 2-bit counter update, combinational read.
// Define BP_FWD_EN to forward a same-cycle update into the read of the same index.
module bp_gshare_pht
    import bp_gshare_pkg::*;
#(
    parameter int PHT_IDX_W = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [PHT_IDX_W-1:0] rd_idx,
    output logic [1:0]           rd_state,
    input  logic                 upd_en,
    input  logic [PHT_IDX_W-1:0] upd_idx,
    input  logic [1:0]           upd_state,
    input  logic                 upd_taken,
    output logic                 ready
);

    localparam int PHT_N = 1 << PHT_IDX_W;

    bp_state_e            state;
    logic [PHT_IDX_W-1:0] ptr;
    logic [1:0]           pht [PHT_N];
    logic                 upd_run;
    logic [1:0]           upd_next;

    function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic dir);
        logic [1:0] nxt;
        case ({dir, cur})
            {1'b1, CTR_SNT}: nxt = CTR_WNT;
            {1'b1, CTR_WNT}: nxt = CTR_WT;
            {1'b1, CTR_WT}:  nxt = CTR_ST;
            {1'b1, CTR_ST}:  nxt = CTR_ST;
            {1'b0, CTR_SNT}: nxt = CTR_SNT;
            {1'b0, CTR_WNT}: nxt = CTR_SNT;
            {1'b0, CTR_WT}:  nxt = CTR_WNT;
            default:         nxt = CTR_WT;
        endcase
        return nxt;
    endfunction

    assign upd_run  = upd_en && (state == ST_RUN);
    assign upd_next = sat_next(upd_state, upd_taken);

    // Sweep writes one entry per cycle; ready rises with the move to RUN.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_INIT;
            ptr   <= '0;
            ready <= 1'b0;
        end else if (state == ST_INIT) begin
            ptr <= ptr + PHT_IDX_W'(1);
            if (ptr == '1) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            pht[ptr] <= PHT_RESET_VAL;
        end else if (upd_run) begin
            pht[upd_idx] <= upd_next;
        end
    end

`ifdef BP_FWD_EN
    assign rd_state = (upd_run && (upd_idx == rd_idx)) ? upd_next : pht[rd_idx];
`else
    assign rd_state = pht[rd_idx];
`endif

endmodule

// File: rtl/bp_gshare.sv
// gshare direction predictor plus direct-mapped tagged BTB with speculative, repairable GHR.
// Define BP_FWD_EN to forward same-cycle PHT/BTB updates into the registered prediction.
module bp_gshare
    import bp_gshare_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int PHT_IDX_W = 10,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 6
) (
    input logic           clk,
    input logic           resetn,
    bp_gshare_if.slave    bp
);

    localparam int TAG_W = tag_width(PC_W, BTB_IDX_W);
    localparam int BTB_N = 1 << BTB_IDX_W;

    logic                 ready;
    logic [GHR_W-1:0]     ghr;
    logic                 accept_p0;

    logic [PHT_IDX_W-1:0] rd_pht_idx_p0;
    logic [PHT_IDX_W-1:0] upd_pht_idx;
    logic [1:0]           rd_state_p0;
    logic                 upd_br;

    logic [BTB_N-1:0]     btb_valid;
    logic [TAG_W-1:0]     btb_tag    [BTB_N];
    logic [PC_W-1:0]      btb_target [BTB_N];
    logic [BTB_IDX_W-1:0] rd_btb_idx_p0;
    logic [BTB_IDX_W-1:0] upd_btb_idx;
    logic [TAG_W-1:0]     rd_tag_p0;
    logic [TAG_W-1:0]     upd_tag;
    logic                 btb_wr;
    logic                 stored_hit_p0;
    logic                 hit_p0;
    logic [PC_W-1:0]      target_p0;

    logic                 vld_p1;
    logic                 taken_p1;
    logic [1:0]           state_p1;
    logic                 hit_p1;
    logic [PC_W-1:0]      target_p1;
    logic [GHR_W-1:0]     ghr_p1;

    logic                 repair;
    logic                 unused_pc_bits;

    function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] hist, input logic bit_in);
        return (hist << 1) | GHR_W'(bit_in);
    endfunction

    assign unused_pc_bits = ^{bp.req_pc[1:0], bp.upd_pc[1:0]};

    assign accept_p0     = bp.req_valid && bp.if_allowin && ready;
    assign rd_pht_idx_p0 = bp.req_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign upd_pht_idx   = bp.upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bp.upd_ghr);
    assign upd_br        = bp.upd_valid && bp.upd_is_br;

    bp_gshare_pht #(
        .PHT_IDX_W (PHT_IDX_W)
    ) u_pht (
        .clk       (clk),
        .resetn    (resetn),
        .rd_idx    (rd_pht_idx_p0),
        .rd_state  (rd_state_p0),
        .upd_en    (upd_br),
        .upd_idx   (upd_pht_idx),
        .upd_state (bp.upd_state),
        .upd_taken (bp.upd_taken),
        .ready     (ready)
    );

    assign rd_btb_idx_p0 = bp.req_pc[BTB_IDX_W+1:2];
    assign rd_tag_p0     = bp.req_pc[PC_W-1:BTB_IDX_W+2];
    assign upd_btb_idx   = bp.upd_pc[BTB_IDX_W+1:2];
    assign upd_tag       = bp.upd_pc[PC_W-1:BTB_IDX_W+2];
    // Any taken control transfer (branch or jump) installs its target.
    assign btb_wr        = bp.upd_valid && bp.upd_taken && ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            btb_valid <= '0;
        end else if (btb_wr) begin
            btb_valid[upd_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[upd_btb_idx]    <= upd_tag;
            btb_target[upd_btb_idx] <= bp.upd_target;
        end
    end

    assign stored_hit_p0 = btb_valid[rd_btb_idx_p0] && (btb_tag[rd_btb_idx_p0] == rd_tag_p0);

`ifdef BP_FWD_EN
    logic btb_fwd_p0;
    assign btb_fwd_p0 = btb_wr && (upd_btb_idx == rd_btb_idx_p0);
    assign hit_p0     = btb_fwd_p0 ? (upd_tag == rd_tag_p0) : stored_hit_p0;
    assign target_p0  = !hit_p0    ? '0 :
                        btb_fwd_p0 ? bp.upd_target : btb_target[rd_btb_idx_p0];
`else
    assign hit_p0    = stored_hit_p0;
    assign target_p0 = hit_p0 ? btb_target[rd_btb_idx_p0] : '0;
`endif

    // ---- p0 -> p1: registered prediction ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vld_p1    <= 1'b0;
            taken_p1  <= 1'b0;
            state_p1  <= '0;
            hit_p1    <= 1'b0;
            target_p1 <= '0;
            ghr_p1    <= '0;
        end else begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                taken_p1  <= rd_state_p0[1] && hit_p0;
                state_p1  <= rd_state_p0;
                hit_p1    <= hit_p0;
                target_p1 <= target_p0;
                ghr_p1    <= ghr;
            end
        end
    end

    // Repair rebuilds history from the snapshot the branch carried, beating any speculative shift.
    assign repair = bp.upd_valid && bp.upd_mispredict && bp.upd_is_br && ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ghr <= '0;
        end else if (repair) begin
            ghr <= ghr_shift(bp.upd_ghr, bp.upd_taken);
        end else if (vld_p1 && hit_p1) begin
            ghr <= ghr_shift(ghr, taken_p1);
        end
    end

    assign bp.bp_ready     = ready;
    assign bp.pred_valid   = vld_p1;
    assign bp.pred_taken   = taken_p1;
    assign bp.pred_state   = state_p1;
    assign bp.pred_btb_hit = hit_p1;
    assign bp.pred_target  = target_p1;
    assign bp.pred_ghr     = ghr_p1;

endmodule

// File: tb/tb_bp_gshare.sv
// Scoreboard bench for bp_gshare: expected predictions are queued at request time
// and compared when pred_valid appears. Build with +define+BP_FWD_EN to match that variant.
`timescale 1ns/1ps
module tb_bp_gshare;

    localparam int PC_W        = 32;
    localparam int PHT_IDX_W   = 8;
    localparam int GHR_W       = 8;
    localparam int BTB_IDX_W   = 6;
    localparam int INIT_CYCLES = 1 << PHT_IDX_W;

    typedef struct packed {
        logic [1:0]       state;
        logic             hit;
        logic             taken;
        logic [PC_W-1:0]  target;
        logic [GHR_W-1:0] ghr;
    } pred_t;

    logic  clk = 1'b0;
    logic  resetn;
    pred_t exp_q[$];
    pred_t mon_e;
    int    n_checks = 0;
    int    n_errors = 0;

    always #5 clk = ~clk;

    bp_gshare_if #(.PC_W(PC_W), .GHR_W(GHR_W)) bp_if ();

    bp_gshare #(
        .PC_W      (PC_W),
        .PHT_IDX_W (PHT_IDX_W),
        .GHR_W     (GHR_W),
        .BTB_IDX_W (BTB_IDX_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bp     (bp_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (bp_if.pred_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pred_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pred_state",  bp_if.pred_state,   mon_e.state);
                check("pred_hit",    bp_if.pred_btb_hit, mon_e.hit);
                check("pred_taken",  bp_if.pred_taken,   mon_e.taken);
                check("pred_target", bp_if.pred_target,  mon_e.target);
                check("pred_ghr",    bp_if.pred_ghr,     mon_e.ghr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_upd();
        bp_if.upd_valid      = 1'b0;
        bp_if.upd_pc         = '0;
        bp_if.upd_is_br      = 1'b0;
        bp_if.upd_taken      = 1'b0;
        bp_if.upd_target     = '0;
        bp_if.upd_state      = '0;
        bp_if.upd_ghr        = '0;
        bp_if.upd_mispredict = 1'b0;
    endtask

    task automatic set_upd(input logic [PC_W-1:0] pc, input logic is_br, input logic taken,
                           input logic [PC_W-1:0] target, input logic [1:0] st,
                           input logic [GHR_W-1:0] g, input logic mis);
        bp_if.upd_valid      = 1'b1;
        bp_if.upd_pc         = pc;
        bp_if.upd_is_br      = is_br;
        bp_if.upd_taken      = taken;
        bp_if.upd_target     = target;
        bp_if.upd_state      = st;
        bp_if.upd_ghr        = g;
        bp_if.upd_mispredict = mis;
    endtask

    task automatic update(input logic [PC_W-1:0] pc, input logic is_br, input logic taken,
                          input logic [PC_W-1:0] target, input logic [1:0] st,
                          input logic [GHR_W-1:0] g, input logic mis);
        set_upd(pc, is_br, taken, target, st, g, mis);
        tick();
        clr_upd();
    endtask

    task automatic request(input logic [PC_W-1:0] pc, input logic [1:0] st, input logic hit,
                           input logic [PC_W-1:0] target, input logic [GHR_W-1:0] g);
        pred_t e;
        e.state  = st;
        e.hit    = hit;
        e.taken  = st[1] & hit;
        e.target = target;
        e.ghr    = g;
        exp_q.push_back(e);
        bp_if.req_valid  = 1'b1;
        bp_if.if_allowin = 1'b1;
        bp_if.req_pc     = pc;
        tick();
        bp_if.req_valid  = 1'b0;
        check("pred_valid_latency", bp_if.pred_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pred_valid"},  bp_if.pred_valid,   0);
        check({tag, "_bp_ready"},    bp_if.bp_ready,     0);
        check({tag, "_pred_taken"},  bp_if.pred_taken,   0);
        check({tag, "_pred_state"},  bp_if.pred_state,   0);
        check({tag, "_pred_hit"},    bp_if.pred_btb_hit, 0);
        check({tag, "_pred_target"}, bp_if.pred_target,  0);
        check({tag, "_pred_ghr"},    bp_if.pred_ghr,     0);
    endtask

    // Requests and a disruptive update are held during INIT; neither may take effect.
    task automatic wait_ready(input string tag);
        int n = 0;
        bit saw_pred = 1'b0;
        bp_if.req_valid  = 1'b1;
        bp_if.if_allowin = 1'b1;
        bp_if.req_pc     = 32'h1C00_0010;
        set_upd(32'h1C00_0010, 1'b1, 1'b1, 32'hDEAD_0000, 2'd0, 8'hFF, 1'b1);
        while (bp_if.bp_ready !== 1'b1 && n < 4 * INIT_CYCLES) begin
            tick();
            n++;
            if (bp_if.pred_valid === 1'b1) saw_pred = 1'b1;
        end
        bp_if.req_valid = 1'b0;
        clr_upd();
        check({tag, "_ready_cycles"}, n, INIT_CYCLES);
        check({tag, "_no_pred_in_init"}, saw_pred, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn           = 1'b0;
        bp_if.req_valid  = 1'b0;
        bp_if.if_allowin = 1'b0;
        bp_if.req_pc     = '0;
        clr_upd();
        repeat (3) tick();
        check_reset_outputs("rst0");

        resetn = 1'b1;
        wait_ready("init0");
        request(32'h1C00_0010, 2'd1, 1'b0, 32'h0, 8'h00);

        update(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, 2'd1, 8'h00, 1'b0);
        request(32'h1C00_0010, 2'd2, 1'b1, 32'h1C00_0100, 8'h00);

        // No accept: valid drops, payload holds. GHR takes the shift of the taken hit (-> 1).
        bp_if.req_valid  = 1'b1;
        bp_if.if_allowin = 1'b0;
        bp_if.req_pc     = 32'h0000_0040;
        tick();
        bp_if.req_valid  = 1'b0;
        bp_if.if_allowin = 1'b1;
        check("hold_valid",  bp_if.pred_valid,   0);
        check("hold_state",  bp_if.pred_state,   2);
        check("hold_hit",    bp_if.pred_btb_hit, 1);
        check("hold_target", bp_if.pred_target,  32'h1C00_0100);

        repeat (4) update(32'h0000_0040, 1'b1, 1'b1, 32'h0000_0200, 2'd3, 8'h01, 1'b0);
        request(32'h0000_0040, 2'd3, 1'b1, 32'h0000_0200, 8'h01);

        repeat (4) update(32'h0000_0080, 1'b1, 1'b0, 32'h0, 2'd0, 8'h03, 1'b0);
        request(32'h0000_0080, 2'd0, 1'b0, 32'h0, 8'h03);

        update(32'h0000_0100, 1'b1, 1'b0, 32'h0, 2'd2, 8'h03, 1'b0);
        request(32'h0000_0100, 2'd1, 1'b0, 32'h0, 8'h03);

        update(32'h1C00_0010, 1'b1, 1'b1, 32'h1C00_0100, 2'd2, 8'h03, 1'b0);
        request(32'h1C00_0010, 2'd3, 1'b1, 32'h1C00_0100, 8'h03);
        // Taken hit is live this cycle, but the mispredict repair must win: {A5<<1 | 0} = 4A.
        update(32'h0000_0000, 1'b1, 1'b0, 32'h0, 2'd3, 8'hA5, 1'b1);
        request(32'h0000_0000, 2'd1, 1'b0, 32'h0, 8'h4A);
        request(32'h0000_03BC, 2'd2, 1'b0, 32'h0, 8'h4A);

        set_upd(32'h0000_00C0, 1'b1, 1'b1, 32'h0000_0500, 2'd1, 8'h4A, 1'b0);
`ifdef BP_FWD_EN
        request(32'h0000_00C0, 2'd2, 1'b1, 32'h0000_0500, 8'h4A);
`else
        request(32'h0000_00C0, 2'd1, 1'b0, 32'h0, 8'h4A);
`endif
        clr_upd();
        request(32'h0000_00C0, 2'd2, 1'b1, 32'h0000_0500, 8'h4A);

        resetn = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst1");
        resetn = 1'b1;
        wait_ready("init1");
        request(32'h1C00_0010, 2'd1, 1'b0, 32'h0, 8'h00);
        request(32'h0000_0040, 2'd1, 1'b0, 32'h0, 8'h00);
        request(32'h0000_00C0, 2'd1, 1'b0, 32'h0, 8'h00);

        tick();
        tick();
        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bp_gshare.md
Name: bp_gshare

Overview:
- Parametrised next-generation branch predictor for the IF stage.
- Combines a gshare PHT (PC XOR speculative global history) with a direct-mapped tagged BTB.
- Adds an init sweep FSM for the PHT and global-history repair on mispredict.
- Prediction is registered one cycle after an accepted fetch request; updates come from the resolving stage.

Parameters:
- PC_W, 32, PC / target width. Instructions are 4-byte aligned, so bits [1:0] are ignored.
- PHT_IDX_W, 10, log2 of PHT entries (2-bit counters).
- GHR_W, 8, global history length. Legal range: 1 ≤ GHR_W ≤ PHT_IDX_W.
- BTB_IDX_W, 6, log2 of BTB entries. Tag width = PC_W − BTB_IDX_W − 2.

Ports:
- clk, in, 1, clock.
- resetn, in, 1, synchronous active-low reset.
- req_valid, in, 1, fetch request valid.
- req_pc, in, PC_W, fetch PC.
- if_allowin, in, 1, IF accepts the request this cycle.
- bp_ready, out, 1, init sweep complete.
- pred_valid, out, 1, prediction valid (one cycle after accept).
- pred_taken, out, 1, predicted taken (pred_state[1] && pred_btb_hit).
- pred_state, out, 2, PHT counter read.
- pred_btb_hit, out, 1, BTB tag hit.
- pred_target, out, PC_W, BTB target.
- pred_ghr, out, GHR_W, GHR snapshot used for the index; carried down the pipe.
- upd_valid, in, 1, resolved branch update.
- upd_pc, in, PC_W, branch PC.
- upd_is_br, in, 1, instruction is a conditional branch.
- upd_taken, in, 1, actual direction.
- upd_target, in, PC_W, actual target.
- upd_state, in, 2, pred_state carried with the branch.
- upd_ghr, in, GHR_W, pred_ghr carried with the branch.
- upd_mispredict, in, 1, direction or target mispredicted.

Behaviour:
- Reset (resetn=0 at posedge):
  - pred_valid=0, bp_ready=0, GHR=0, all BTB valid bits=0.
  - All registered pred_* outputs = 0.
  - FSM enters INIT with sweep pointer = 0.
- FSM INIT:
  - Writes 2'b01 (weakly not-taken) to PHT[ptr]; ptr increments by 1 each cycle.
  - After writing entry 2^PHT_IDX_W−1, moves to RUN. INIT lasts exactly 2^PHT_IDX_W cycles.
  - bp_ready asserts on the first RUN cycle.
  - During INIT: pred_valid=0, updates are ignored, requests are not accepted.
- A reset asserted mid-INIT or mid-RUN restarts INIT from ptr 0.
- Accept = req_valid && if_allowin && bp_ready.
  - Next cycle: pred_valid=1; pred_* reflect req_pc.
  - With no accept, pred_valid=0 next cycle and the other pred_* hold their values.
- PHT index = req_pc[PHT_IDX_W+1:2] XOR {zeros, GHR}.
- BTB index = req_pc[BTB_IDX_W+1:2].
  - Hit = valid && tag == req_pc[PC_W−1:BTB_IDX_W+2].
  - pred_target = 0 on miss.
- Speculative GHR:
  - In a cycle where pred_valid && pred_btb_hit, GHR <= {GHR[GHR_W−2:0], pred_taken}.
  - GHR_W=1 means GHR <= pred_taken.
- Repair: if upd_valid && upd_mispredict && upd_is_br, GHR <= {upd_ghr[GHR_W−2:0], upd_taken}. Repair overrides a same-cycle speculative shift.
- PHT update:
  - Trigger: upd_valid && upd_is_br in RUN.
  - Index = upd_pc[PHT_IDX_W+1:2] XOR upd_ghr.
  - New value = upd_state+1 if taken, else upd_state−1, saturating at 3 and 0.
- BTB update:
  - Trigger: upd_valid && upd_taken in RUN (branch or jump).
  - Writes valid=1, tag, upd_target; the existing entry is overwritten.
  - A not-taken branch leaves the BTB unchanged.
- Same-cycle read/write to the same PHT or BTB index: the read returns the old value (no forwarding), unless BP_FWD_EN is defined.
- Counter arithmetic is 2-bit unsigned; no wrap past 3 or 0.

Optional Feature:
- Macro: BP_FWD_EN.
- Defined: a same-cycle update to the index being read forwards the new PHT state and new BTB entry into the registered prediction.
- Undefined: the old value is returned, as stated above.

Decomposition:
- Shared header bp_gshare_pkg.vh:
  - Counter encodings SNT=0, WNT=1, WT=2, ST=3.
  - INIT/RUN state encodings.
  - PHT_RESET_VAL = WNT.
  - Macro for tag width.
- One sub-module, bp_gshare_pht: PHT storage, init sweep pointer/FSM, saturating update and optional forward.
- The BTB and GHR stay in the top.

Test Plan:
- Reset with PHT_IDX_W=4: bp_ready rises exactly 16 cycles after resetn goes 1. A request during INIT gives pred_valid=0. The first RUN request reads pred_state=1.
- Upd pc=0x1C000010, taken, target 0x1C000100, state=1, ghr=0. Then request the same pc with GHR=0 → btb_hit=1, target=0x1C000100, state=2, pred_taken=1, pred_valid one cycle after accept.
- Four taken updates, starting from state=3 → state stays 3. Four not-taken updates, starting from state=0 → state stays 0.
- Predicted taken hit → GHR shifts in 1. The same cycle carries a mispredict with upd_ghr=8'hA5, upd_taken=0 → GHR=8'h4A (repair wins).
- Update and read of the same index in one cycle: without BP_FWD_EN the old state is returned. With it, the new state is returned.
- Assert resetn=0 mid-stream after BTB fills → all hits=0, GHR=0, full INIT re-run.
